// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit scheduler.
// rr_pick works on a 16-wide request vector so one function serves every NUM_REQ.
package uart_pkg;

  localparam int UART_DATA_W = 8;
  localparam int MAX_REQ     = 16;
  localparam int REQ_IDX_W   = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } sched_state_t;

  // First set bit at or above ptr, wrapping at num_req; 0 when nothing is set.
  function automatic logic [REQ_IDX_W-1:0] rr_pick(
    input logic [MAX_REQ-1:0]   req,
    input logic [REQ_IDX_W-1:0] ptr,
    input int                   num_req
  );
    logic [REQ_IDX_W-1:0] win;
    logic                 found;
    int                   idx;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= num_req) idx = idx - num_req;
      if (!found && (k < num_req) && req[idx[REQ_IDX_W-1:0]]) begin
        win   = idx[REQ_IDX_W-1:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin pick: lowest set request at or above ptr, wrapping.
// The owner keeps the pointer; this block only looks.
module uart_rr_arbiter
  import uart_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               valid,
  output logic [ID_W-1:0]    idx
);

  logic [MAX_REQ-1:0]   req_ext;
  logic [REQ_IDX_W-1:0] ptr_ext;
  logic [REQ_IDX_W-1:0] pick;

  always_comb begin
    req_ext              = '0;
    req_ext[NUM_REQ-1:0] = req;
    ptr_ext              = '0;
    ptr_ext[ID_W-1:0]    = ptr;
    pick                 = rr_pick(req_ext, ptr_ext, NUM_REQ);
    valid                = |req;
    idx                  = pick[ID_W-1:0];
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one uart_tx between NUM_REQ byte producers: round-robin grant, start/done
// sequencing, completion watchdog and a minimum idle gap between frames.
//
// Handshake: req[i] is a level held until grant[i] pulses; the byte on req_data is
// taken in the cycle the scheduler sits in IDLE and picks i, and grant[i] pulses the
// next cycle together with tx_start. tx_din stays put until the following grant.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter  int NUM_REQ          = 4,
  parameter  int NUM_CLKS_PER_BIT = 16,
  parameter  int TIMEOUT_CLKS     = NUM_CLKS_PER_BIT * 12,
  parameter  int GAP_CLKS         = NUM_CLKS_PER_BIT,
  localparam int ID_W             = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           tx_clk,
  input  logic                           tx_rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*UART_DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]             grant,
  output logic                           busy,
  output logic                           tx_start,
  output logic [UART_DATA_W-1:0]         tx_din,
  input  logic                           tx_done,
  output logic                           frame_done,
  output logic [ID_W-1:0]                frame_id,
  output logic                           timeout,
  output sched_state_t                   state_dbg
);

  localparam int TIMER_MAX = (TIMEOUT_CLKS > GAP_CLKS) ? TIMEOUT_CLKS : GAP_CLKS;
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CLKS - 1);
  // GAP_CLKS of 0 or 1 both give a single GAP cycle.
  localparam logic [TIMER_W-1:0] GAP_LAST = TIMER_W'((GAP_CLKS > 1) ? GAP_CLKS - 1 : 0);

  sched_state_t         state, state_nxt;
  logic [ID_W-1:0]      rr_ptr, rr_ptr_nxt;
  logic [TIMER_W-1:0]   timer;
  logic                 tx_done_q;
  logic                 done_rise, timer_exp, gap_end;
  logic                 arb_valid;
  logic [ID_W-1:0]      arb_idx;
  logic [UART_DATA_W-1:0] win_byte;

  uart_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (req),
    .ptr   (rr_ptr),
    .valid (arb_valid),
    .idx   (arb_idx)
  );

  assign done_rise = tx_done & ~tx_done_q;
  assign timer_exp = (timer == TIMEOUT_LAST);
  assign gap_end   = (timer == GAP_LAST);

  always_comb begin
    win_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == ID_W'(i)) win_byte = req_data[i*UART_DATA_W +: UART_DATA_W];
    end
  end

  assign rr_ptr_nxt = (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;

  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (arb_valid) state_nxt = START;
      START:     state_nxt = WAIT_DONE;
      WAIT_DONE: if (done_rise || timer_exp) state_nxt = GAP;
      GAP:       if (gap_end) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    tx_start  = (state == START);
    state_dbg = state;
  end

  // Datapath: capture on pick, watchdog/gap timer, one-cycle event pulses.
  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      rr_ptr     <= '0;
      grant      <= '0;
      tx_din     <= '0;
      frame_id   <= '0;
      frame_done <= 1'b0;
      timeout    <= 1'b0;
      timer      <= '0;
      tx_done_q  <= 1'b0;
    end else begin
      tx_done_q  <= tx_done;
      grant      <= '0;
      frame_done <= 1'b0;
      timeout    <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_valid) begin
            tx_din   <= win_byte;
            frame_id <= arb_idx;
            grant    <= NUM_REQ'(1) << arb_idx;
            rr_ptr   <= rr_ptr_nxt;
          end
        end
        START: timer <= '0;
        WAIT_DONE: begin
          // A completion edge landing on the last timer cycle still counts as done.
          if (done_rise) begin
            frame_done <= 1'b1;
            timer      <= '0;
          end else if (timer_exp) begin
            timeout <= 1'b1;
            timer   <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        GAP: if (!gap_end) timer <= timer + 1'b1;
        default: ;
      endcase
    end
  end

endmodule
